// File: rtl/gal_olmc_cfg_ctrl.sv
// rtl/gal_olmc_cfg_ctrl.sv - serial configuration frame loader for GAL OLMC mode bits
module gal_olmc_cfg_ctrl #(
    parameter int          N_OLMC = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic              C,
    input  logic              R,
    input  logic              START,
    input  logic              SDI,
    input  logic              SDV,
    output logic [N_OLMC-1:0] CFG_REG,
    output logic [N_OLMC-1:0] CFG_INV,
    output logic [N_OLMC-1:0] CFG_OE,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int NB = 3 * N_OLMC;
    localparam int CW = ($clog2(NB) < 3) ? 3 : $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_PAR,
        S_COMMIT,
        S_FAIL
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [7:0]        hdr, hdr_n;
    logic [NB-1:0]     shadow, shadow_n;
    logic              cfg_load;
    logic [N_OLMC-1:0] reg_n, inv_n, oe_n;

    // Next-state logic; START always restarts the frame and wins over any bit in the same cycle
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hdr_n    = hdr;
        shadow_n = shadow;
        cfg_load = 1'b0;
        case (state)
            S_IDLE: ;
            S_HDR: begin
                if (SDV) begin
                    hdr_n = {hdr[6:0], SDI};
                    if (cnt == CW'(7)) begin
                        cnt_n   = '0;
                        state_n = (hdr_n == HEADER) ? S_DATA : S_FAIL;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_DATA: begin
                if (SDV) begin
                    // First received bit ends up in shadow[0] after the last shift
                    shadow_n = {SDI, shadow[NB-1:1]};
                    if (cnt == CW'(NB - 1)) begin
                        cnt_n   = '0;
                        state_n = S_PAR;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            S_PAR: begin
                if (SDV) begin
                    if (((^shadow) ^ SDI) == 1'b0) begin
                        state_n  = S_COMMIT;
                        cfg_load = 1'b1;
                    end else begin
                        state_n = S_FAIL;
                    end
                end
            end
            S_COMMIT: state_n = S_IDLE;
            S_FAIL:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (START) begin
            state_n  = S_HDR;
            cnt_n    = '0;
            hdr_n    = '0;
            shadow_n = '0;
            cfg_load = 1'b0;
        end
    end

    // Split the shadow into per-OLMC fields: each OLMC occupies REG, INV, OE in arrival order
    always_comb begin
        reg_n = '0;
        inv_n = '0;
        oe_n  = '0;
        for (int i = 0; i < N_OLMC; i++) begin
            reg_n[i] = shadow[3*i];
            inv_n[i] = shadow[3*i+1];
            oe_n[i]  = shadow[3*i+2];
        end
    end

    // State, datapath and registered outputs; status flags are registered from the next state
    always_ff @(posedge C) begin
        if (R) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hdr     <= '0;
            shadow  <= '0;
            CFG_REG <= '0;
            CFG_INV <= '0;
            CFG_OE  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hdr    <= hdr_n;
            shadow <= shadow_n;
            if (cfg_load) begin
                CFG_REG <= reg_n;
                CFG_INV <= inv_n;
                CFG_OE  <= oe_n;
            end
            BUSY <= (state_n == S_HDR) || (state_n == S_DATA) || (state_n == S_PAR);
            DONE <= (state_n == S_COMMIT);
            ERR  <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_gal_olmc_cfg_ctrl.sv
// tb/tb_gal_olmc_cfg_ctrl.sv - scoreboard bench for gal_olmc_cfg_ctrl with N_OLMC=2
module tb_gal_olmc_cfg_ctrl;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       START = 1'b0;
    logic       SDI = 1'b0;
    logic       SDV = 1'b0;
    logic [1:0] CFG_REG, CFG_INV, CFG_OE;
    logic       BUSY, DONE, ERR;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit         is_done;
        int         cyc;
        logic [1:0] r;
        logic [1:0] i;
        logic [1:0] o;
    } exp_t;

    exp_t q[$];
    logic [1:0] mon_r = '0, mon_i = '0, mon_o = '0;

    gal_olmc_cfg_ctrl #(.N_OLMC(2), .HEADER(8'hA5)) dut (
        .C(C), .R(R), .START(START), .SDI(SDI), .SDV(SDV),
        .CFG_REG(CFG_REG), .CFG_INV(CFG_INV), .CFG_OE(CFG_OE),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 C = ~C;

    always @(posedge C) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per DONE/ERR pulse and tracks the committed configuration
    always @(negedge C) begin
        if (cyc > 0) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (DONE || ERR) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", int'({DONE, ERR}), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_done", int'(DONE), int'(e.is_done));
                    chk("pulse_err", int'(ERR), int'(!e.is_done));
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("busy_at_pulse", int'(BUSY), 0);
                    if (e.is_done) begin
                        mon_r = e.r;
                        mon_i = e.i;
                        mon_o = e.o;
                    end
                end
            end
            chk("cfg", int'({CFG_REG, CFG_INV, CFG_OE}), int'({mon_r, mon_i, mon_o}));
            if (R) begin
                mon_r = '0;
                mon_i = '0;
                mon_o = '0;
            end
        end
    end

    task automatic drive(input logic st, input logic d, input logic v);
        @(posedge C);
        #1;
        START = st;
        SDI   = d;
        SDV   = v;
    endtask

    task automatic send_bit(input logic b, input int stall_pct, output int c);
        while (int'($urandom_range(99)) < stall_pct) drive(1'b0, 1'($urandom), 1'b0);
        drive(1'b0, b, 1'b1);
        c = cyc;
    endtask

    // Sends START, header, cfg bits b[0..5] in order, parity; abort_at stops after that many bits
    task automatic send_frame(input logic [7:0] h, input logic [5:0] b, input logic p,
                              input int abort_at, input int stall_pct, input int gap);
        int   c;
        bit   alive;
        logic bitv;
        exp_t e;
        drive(1'b1, 1'($urandom), 1'($urandom));
        drive(1'b0, 1'($urandom), 1'b0);
        @(negedge C);
        chk("busy_after_start", int'(BUSY), 1);
        alive = 1;
        for (int k = 0; k < 15; k++) begin
            if (k == abort_at) return;
            bitv = (k < 8) ? h[7-k] : (k < 14) ? b[k-8] : p;
            send_bit(bitv, stall_pct, c);
            if (k == 7 && h != 8'hA5) begin
                e.is_done = 0; e.cyc = c + 1; e.r = '0; e.i = '0; e.o = '0;
                q.push_back(e);
                alive = 0;
            end
            if (k == 14 && alive) begin
                e.cyc = c + 1;
                e.is_done = (($countones(b) + int'(p)) % 2) == 0;
                e.r = {b[3], b[0]};
                e.i = {b[4], b[1]};
                e.o = {b[5], b[2]};
                q.push_back(e);
            end
        end
        repeat (gap) drive(1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(posedge C);
        #1;
        R = 1'b1; START = 1'b1; SDV = 1'b1;
        repeat (2) @(posedge C);
        #1;
        R = 1'b0; START = 1'b0; SDV = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        @(negedge C);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_done"}, int'(DONE), 0);
        chk({tag, "_err"}, int'(ERR), 0);
        chk({tag, "_cfg"}, int'({CFG_REG, CFG_INV, CFG_OE}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] h;
        logic [5:0] b;
        logic       p;
        repeat (3) @(posedge C);
        #1;
        R = 1'b0;
        idle_checks("reset");

        send_frame(8'hA5, 6'b110101, 1'b0, -1, 0, 2);
        send_frame(8'hA5, 6'b110101, 1'b1, -1, 0, 2);
        send_frame(8'hA4, 6'b110101, 1'b0, -1, 0, 2);
        send_frame(8'hA5, 6'b000000, 1'b0, -1, 0, 1);
        send_frame(8'hA5, 6'b110101, 1'b0, -1, 50, 2);
        send_frame(8'hA5, 6'b110101, 1'b0, 11, 0, 0);
        send_frame(8'hA5, 6'b001110, 1'b1, -1, 0, 2);
        send_frame(8'hA5, 6'b110101, 1'b0, -1, 0, 1);
        send_frame(8'hA5, 6'b011011, 1'b0, 3, 0, 0);
        do_reset();
        idle_checks("mid_frame_reset");

        for (int n = 0; n < 40; n++) begin
            h = (int'($urandom_range(99)) < 80) ? 8'hA5 : 8'($urandom);
            b = 6'($urandom);
            p = (^b) ^ (int'($urandom_range(99)) < 30);
            send_frame(h, b, p,
                       (int'($urandom_range(99)) < 20) ? int'($urandom_range(14)) : -1,
                       int'($urandom_range(60)), int'($urandom_range(3)));
        end

        repeat (6) drive(1'b0, 1'b0, 1'b0);
        @(negedge C);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
